// File: rtl/riscv_core_pkg.sv
// Shared riscv_core definitions: 2-bit branch counter encoding, counter width
// and the default predictor depth.
package riscv_core_pkg;

  localparam int BP_CNT_W           = 2;
  localparam int BP_ENTRIES_DEFAULT = 64;

  typedef enum logic [BP_CNT_W-1:0] {
    BP_SNT = 2'b00,
    BP_WNT = 2'b01,
    BP_WT  = 2'b10,
    BP_ST  = 2'b11
  } bp_cnt_e;

  // The counter's upper bit is the taken/not-taken direction.
  function automatic logic bp_cnt_taken(input bp_cnt_e cnt);
    return cnt[BP_CNT_W-1];
  endfunction

endpackage

// File: rtl/riscv_core_bp_sat_counter.sv
// Next-state logic for one 2-bit saturating branch counter.
module riscv_core_bp_sat_counter
  import riscv_core_pkg::*;
(
  input  bp_cnt_e cnt,
  input  logic    taken,
  output bp_cnt_e cnt_next
);

  // Step toward ST on taken, toward SNT on not-taken, holding at either end.
  always_comb begin
    cnt_next = cnt;
    case (cnt)
      BP_SNT:  cnt_next = taken ? BP_WNT : BP_SNT;
      BP_WNT:  cnt_next = taken ? BP_WT  : BP_SNT;
      BP_WT:   cnt_next = taken ? BP_ST  : BP_WNT;
      BP_ST:   cnt_next = taken ? BP_ST  : BP_WT;
      default: cnt_next = BP_WNT;
    endcase
  end

endmodule

// File: rtl/riscv_core_branch_predictor.sv
// Bimodal branch predictor: direct-mapped table of 2-bit counters plus a tagged
// BTB. Fetch reads the table combinationally; execute-stage resolutions train
// it and raise a registered flush/redirect on a mispredict.
module riscv_core_branch_predictor
  import riscv_core_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int BP_ENTRIES = BP_ENTRIES_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [XLEN-1:0] i_bp_fetch_pc,
  output logic            o_bp_predict_taken,
  output logic [XLEN-1:0] o_bp_predict_target,
  input  logic            i_bp_update_valid,
  input  logic [XLEN-1:0] i_bp_update_pc,
  input  logic            i_bp_update_istaken,
  input  logic [XLEN-1:0] i_bp_update_target,
  input  logic            i_bp_update_is_compressed,
  input  logic            i_bp_update_pred_taken,
  input  logic [XLEN-1:0] i_bp_update_pred_target,
  output logic            o_bp_flush,
  output logic [XLEN-1:0] o_bp_redirect_pc,
  output logic [31:0]     o_bp_mispredict_cnt
);

  localparam int IDX_W = $clog2(BP_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 1;

  // Fall-through PC after a not-taken branch; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] seq_pc(input logic [XLEN-1:0] pc,
                                             input logic            compressed);
    return pc + (compressed ? XLEN'(2) : XLEN'(4));
  endfunction

  // Mispredict counter increment that sticks at all-ones.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Predictor storage
  bp_cnt_e               cnt_q     [BP_ENTRIES];
  logic [BP_ENTRIES-1:0] btb_vld_q;
  logic [TAG_W-1:0]      btb_tag_q [BP_ENTRIES];
  logic [XLEN-1:0]       btb_tgt_q [BP_ENTRIES];

  // Registered mispredict outputs
  logic                  vld_p1;
  logic [XLEN-1:0]       redirect_pc_p1;
  logic [31:0]           mis_cnt_p1;

  logic [IDX_W-1:0]      fetch_idx;
  logic [TAG_W-1:0]      fetch_tag;
  logic                  fetch_hit;
  logic [IDX_W-1:0]      upd_idx;
  logic [TAG_W-1:0]      upd_tag;
  logic                  upd_mispredict;
  logic [XLEN-1:0]       upd_redirect;
  bp_cnt_e               upd_cnt_next;
  logic                  unused_fetch_lsb;

  assign fetch_idx        = i_bp_fetch_pc[IDX_W:1];
  assign fetch_tag        = i_bp_fetch_pc[XLEN-1:IDX_W+1];
  assign upd_idx          = i_bp_update_pc[IDX_W:1];
  assign upd_tag          = i_bp_update_pc[XLEN-1:IDX_W+1];
  assign unused_fetch_lsb = i_bp_fetch_pc[0];

  // Fetch-side lookup from stored state only, so a same-cycle update is not seen.
  always_comb begin
    fetch_hit           = btb_vld_q[fetch_idx] && (btb_tag_q[fetch_idx] == fetch_tag);
    o_bp_predict_taken  = bp_cnt_taken(cnt_q[fetch_idx]) && fetch_hit;
    o_bp_predict_target = o_bp_predict_taken ? btb_tgt_q[fetch_idx] : '0;
  end

  assign upd_mispredict = i_bp_update_valid &&
                          ((i_bp_update_istaken != i_bp_update_pred_taken) ||
                           (i_bp_update_istaken &&
                            (i_bp_update_target != i_bp_update_pred_target)));

  assign upd_redirect = i_bp_update_istaken ? i_bp_update_target
                                            : seq_pc(i_bp_update_pc, i_bp_update_is_compressed);

  riscv_core_bp_sat_counter u_upd_counter (
    .cnt      (cnt_q[upd_idx]),
    .taken    (i_bp_update_istaken),
    .cnt_next (upd_cnt_next)
  );

  // Counters and BTB valid bits: reset to weakly-not-taken / invalid, trained on update.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BP_ENTRIES; i++) begin
        cnt_q[i] <= BP_WNT;
      end
      btb_vld_q <= '0;
    end else if (i_bp_update_valid) begin
      cnt_q[upd_idx] <= upd_cnt_next;
      if (i_bp_update_istaken) begin
        btb_vld_q[upd_idx] <= 1'b1;
      end
    end
  end

  // BTB tag/target payload: unreset, written only by taken branches outside reset.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && i_bp_update_valid && i_bp_update_istaken) begin
      btb_tag_q[upd_idx] <= upd_tag;
      btb_tgt_q[upd_idx] <= i_bp_update_target;
    end
  end

  // Mispredict stage: one-cycle flush pulse, held redirect PC, saturating count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p1         <= 1'b0;
      redirect_pc_p1 <= '0;
      mis_cnt_p1     <= '0;
    end else begin
      vld_p1 <= upd_mispredict;
      if (upd_mispredict) begin
        redirect_pc_p1 <= upd_redirect;
        mis_cnt_p1     <= sat_inc32(mis_cnt_p1);
      end
    end
  end

  assign o_bp_flush          = vld_p1;
  assign o_bp_redirect_pc    = redirect_pc_p1;
  assign o_bp_mispredict_cnt = mis_cnt_p1;

endmodule
